// File: rtl/rng_pkg.sv
// Shared widths and the streamer state type for the rng block streamer.
// Constants only; no latency and no flow control of its own.
package rng_pkg;
  localparam int WORD_W  = 32;
  localparam int WORDS   = 16;
  localparam int KEY_W   = 256;
  localparam int BLOCK_W = WORDS * WORD_W;
  localparam int IDX_W   = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP,
    DRAIN
  } rng_state_t;
endpackage

// File: rtl/rng_word_buffer.sv
// One captured core block served word by word; load takes 1 cycle and word 0 shows the next cycle.
// A pop advances one word per cycle, and the pop of the last word empties the buffer; flush wins over load and pop.
module rng_word_buffer
  import rng_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_dat,
  input  logic               pop,
  output logic [WORD_W-1:0]  word,
  output logic               full,
  output logic               last
);
  logic [WORDS-1:0][WORD_W-1:0] blk_q;
  logic [IDX_W-1:0]             idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_q <= '0;
      idx_q <= '0;
      full  <= 1'b0;
    end else if (flush) begin
      idx_q <= '0;
      full  <= 1'b0;
    end else if (load) begin
      blk_q <= load_dat;
      idx_q <= '0;
      full  <= 1'b1;
    end else if (pop && full) begin
      idx_q <= idx_q + IDX_W'(1);
      if (last) full <= 1'b0;
    end
  end

  assign word = blk_q[idx_q];
  assign last = (idx_q == IDX_W'(WORDS - 1));
endmodule

// File: rtl/rng_block_streamer.sv
// Keys the chacha core per block, captures its 512-bit output and streams 32-bit words; word 0 appears 1 cycle after intr.
// Holds rnd_data while stalled; RNG_PREFETCH_EN adds a spare buffer so the next block is fetched while this one drains.
module rng_block_streamer
  import rng_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   seed,
  input  logic               seed_load,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_valid,
  input  logic               core_intr,
  input  logic [BLOCK_W-1:0] core_out,
  output logic [WORD_W-1:0]  rnd_data,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic [WORD_W-1:0]  blk_cnt_o
);
  rng_state_t        state_q, state_d;
  logic [KEY_W-1:0]  seed_q;
  logic [WORD_W-1:0] blk_cnt;
  logic              load, pop, last;
  logic              gen_ok, drain_exit;

  // A handshake coinciding with a reseed is discarded, so it never advances the buffer.
  assign pop       = rnd_valid && rnd_ready && !seed_load;
  assign blk_cnt_o = blk_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      seed_q  <= '0;
      blk_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (seed_load) begin
        seed_q  <= seed;
        blk_cnt <= '0;
      end else if (pop && last) begin
        blk_cnt <= blk_cnt + WORD_W'(1);
      end
    end
  end

`ifdef RNG_PREFETCH_EN
  logic [1:0]             full_v, last_v, load_v, pop_v;
  logic [1:0][WORD_W-1:0] word_v;
  logic                   cur_q, tgt;
  logic [WORD_W-1:0]      gen_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_buf
    rng_word_buffer u_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (seed_load),
      .load     (load_v[g]),
      .load_dat (core_out),
      .pop      (pop_v[g]),
      .word     (word_v[g]),
      .full     (full_v[g]),
      .last     (last_v[g])
    );
  end

  assign rnd_valid = full_v[cur_q];
  assign rnd_data  = word_v[cur_q];
  assign last      = last_v[cur_q];
  // Fill the draining buffer if it is empty, otherwise the spare, so blocks leave in key order.
  assign tgt       = full_v[cur_q] ? ~cur_q : cur_q;
  assign pop_v     = {pop && cur_q, pop && !cur_q};
  assign load_v    = {load && tgt, load && !tgt};
  assign core_key  = {seed_q[KEY_W-1:WORD_W], seed_q[WORD_W-1:0] ^ gen_cnt};
  assign gen_ok    = !(&full_v);
  assign drain_exit = !(&full_v);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q   <= 1'b0;
      gen_cnt <= '0;
    end else if (seed_load) begin
      cur_q   <= 1'b0;
      gen_cnt <= '0;
    end else begin
      if (pop && last) cur_q <= ~cur_q;
      if (load) gen_cnt <= gen_cnt + WORD_W'(1);
    end
  end
`else
  logic full;

  rng_word_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (seed_load),
    .load     (load),
    .load_dat (core_out),
    .pop      (pop),
    .word     (rnd_data),
    .full     (full),
    .last     (last)
  );

  assign rnd_valid  = full;
  assign core_key   = {seed_q[KEY_W-1:WORD_W], seed_q[WORD_W-1:0] ^ blk_cnt};
  assign gen_ok     = 1'b1;
  assign drain_exit = pop && last;
`endif

  always_comb begin
    state_d    = state_q;
    core_valid = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE:  state_d = IDLE;
      DROP:  if (!core_intr && gen_ok) state_d = REQ;
      REQ: begin
        core_valid = 1'b1;
        if (core_intr) begin
          load    = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: if (drain_exit) state_d = DROP;
      default: state_d = IDLE;
    endcase
    // Reseed beats a completing core request; that block is dropped.
    if (seed_load) begin
      load    = 1'b0;
      state_d = DROP;
    end
  end
endmodule

// File: tb/tb_rng_block_streamer.sv
// Scoreboard bench for rng_block_streamer with a behavioural chacha stand-in.
// Expected words are queued when a block is keyed and compared on every handshake.
module tb_rng_block_streamer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] seed = '0;
  logic         seed_load = 1'b0;
  logic [255:0] core_key;
  logic         core_valid;
  logic         core_intr;
  logic [511:0] core_out;
  logic [31:0]  rnd_data;
  logic         rnd_valid;
  logic         rnd_ready = 1'b0;
  logic [31:0]  blk_cnt_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          core_cnt;
  logic        stall_q = 1'b0;
  logic [31:0] stall_dat = '0;

  always #5 clk = ~clk;

  rng_block_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .seed_load  (seed_load),
    .core_key   (core_key),
    .core_valid (core_valid),
    .core_intr  (core_intr),
    .core_out   (core_out),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .blk_cnt_o  (blk_cnt_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_block(input logic [31:0] key_lo);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = key_lo ^ 32'(i);
    return b;
  endfunction

  // Core stand-in: intr rises 20 cycles after valid, falls once valid drops.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_cnt  <= 0;
      core_intr <= 1'b0;
      core_out  <= '0;
    end else if (!core_valid) begin
      core_cnt  <= 0;
      core_intr <= 1'b0;
    end else if (!core_intr) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 19) begin
        core_intr <= 1'b1;
        core_out  <= mk_block(core_key[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst || seed_load) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_vld", rnd_valid, 1'b1);
        chk("hold_dat", rnd_data, stall_dat);
      end
      if (rnd_valid && rnd_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", rnd_valid, 1'b0);
        else chk("word", rnd_data, exp_q.pop_front());
      end
      stall_q   = rnd_valid && !rnd_ready;
      stall_dat = rnd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_seed(input logic [31:0] lo);
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), lo};
  endfunction

  task automatic do_seed(input logic [255:0] s);
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic push_block(input logic [31:0] key_lo);
    for (int i = 0; i < 16; i++) exp_q.push_back(key_lo ^ 32'(i));
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_intr();
    int n = 0;
    while (!core_intr && n < 60) begin
      tick();
      n++;
    end
    chk("wait_intr", core_intr, 1'b1);
  endtask

  initial begin
    logic [255:0] s;
    int n;
    int cnt_cv;
    int cnt_rv;
    int gaps;

    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst_core_valid", core_valid, 1'b0);
    chk("rst_core_key", core_key, '0);
    chk("rst_rnd_valid", rnd_valid, 1'b0);
    chk("rst_rnd_data", rnd_data, '0);
    chk("rst_blk_cnt", blk_cnt_o, '0);
    rst = 1'b1;
    tick();

`ifdef RNG_PREFETCH_EN
    s = mk_seed(32'h20);
    do_seed(s);
    push_block(32'h20);
    push_block(32'h21);
    repeat (60) tick();
    chk("pf_spare_full", dut.full_v, 2'b11);
    rnd_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 32; i++) begin
      if (!rnd_valid) gaps++;
      tick();
    end
    rnd_ready = 1'b0;
    chk("pf_gaps", gaps, 0);
    chk("pf_left", exp_q.size(), 0);
    chk("pf_blk_cnt", blk_cnt_o, 32'd2);
`else
    // Basic stream, key and first-word latency.
    rnd_ready = 1'b1;
    s = mk_seed(32'h1);
    do_seed(s);
    push_block(32'h1);
    chk("cv_t1", core_valid, 1'b0);
    tick();
    chk("cv_t2", core_valid, 1'b1);
    chk("key_hi", core_key[255:32], s[255:32]);
    chk("key_lo0", core_key[31:0], 32'h1);
    wait_intr();
    tick();
    chk("c1_core_valid", core_valid, 1'b0);
    chk("c1_rnd_valid", rnd_valid, 1'b1);
    chk("c1_word0", rnd_data, 32'h1);
    wait_drained("drain_basic");
    rnd_ready = 1'b0;
    chk("blk_cnt_1", blk_cnt_o, 32'd1);
    chk("key_lo1", core_key[31:0], 32'h0);

    // Consumer stalling every other cycle.
    s = mk_seed(32'h100);
    do_seed(s);
    push_block(32'h100);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      rnd_ready = ~rnd_ready;
      tick();
      n++;
    end
    rnd_ready = 1'b0;
    chk("drain_toggle", exp_q.size(), 0);

    // Reseed while word 5 is being accepted.
    s = mk_seed(32'h55);
    do_seed(s);
    push_block(32'h55);
    rnd_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 11 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_pos", exp_q.size(), 11);
    seed      = mk_seed(32'hA);
    seed_load = 1'b1;
    exp_q.delete();
    push_block(32'hA);
    tick();
    seed_load = 1'b0;
    chk("flush_vld", rnd_valid, 1'b0);
    chk("flush_cnt", blk_cnt_o, '0);
    wait_drained("drain_reseed");
    rnd_ready = 1'b0;

    // Block counter wrap.
    s = mk_seed(32'h3C);
    do_seed(s);
    n = 0;
    while (!rnd_valid && n < 60) begin
      tick();
      n++;
    end
    chk("wrap_vld", rnd_valid, 1'b1);
    force dut.blk_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.blk_cnt;
    chk("wrap_pre", blk_cnt_o, 32'hFFFF_FFFF);
    push_block(32'h3C);
    rnd_ready = 1'b1;
    wait_drained("drain_wrap");
    rnd_ready = 1'b0;
    chk("wrap_cnt", blk_cnt_o, '0);
    chk("wrap_key", core_key[31:0], 32'h3C);

    // Reset in the middle of a core request.
    s = mk_seed(32'h77);
    do_seed(s);
    n = 0;
    while (!core_valid && n < 10) begin
      tick();
      n++;
    end
    chk("req_seen", core_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_core_valid", core_valid, 1'b0);
    chk("arst_rnd_valid", rnd_valid, 1'b0);
    chk("arst_core_key", core_key, '0);
    tick();
    rst = 1'b1;
    rnd_ready = 1'b1;
    cnt_cv = 0;
    cnt_rv = 0;
    for (int i = 0; i < 40; i++) begin
      if (core_valid) cnt_cv++;
      if (rnd_valid) cnt_rv++;
      tick();
    end
    rnd_ready = 1'b0;
    chk("idle_core_valid", cnt_cv, 0);
    chk("idle_rnd_valid", cnt_rv, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
